// File: rtl/otter_trap_ctrl.sv
// -----------------------------------------------------------------------------
// otter_trap_ctrl
// Machine-mode trap sequencer for the OTTER core. It takes synchronous
// exceptions, level-sensitive external interrupts and MRET, and turns them
// into a CSR write cycle (mepc/mcause/mtval) followed by a fetch redirect.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   trap_req/cause/pc/val : exception request and its cause, PC and mtval
//   irq_ext, mie          : external interrupt level and global enable
//   next_pc               : resume PC saved as mepc for interrupts
//   mret                  : decoded MRET
//   mtvec, mepc_q         : current CSR values
//   redir_ready           : fetch accepts the redirect
//   flush                 : squash in-flight instructions
//   redir_valid/addr      : redirect request and target
//   csr_we, *_wd          : joint write of mepc, mcause, mtval
//   mie_clr, mie_restore  : clear MIE / restore MIE from MPIE
//   busy                  : sequencer is not idle
// -----------------------------------------------------------------------------
module otter_trap_ctrl #(
    parameter int unsigned IRQ_CAUSE = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        irq_ext,
    input  logic        mie,
    input  logic [31:0] next_pc,
    input  logic        mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_q,
    input  logic        redir_ready,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_addr,
    output logic        csr_we,
    output logic [31:0] mepc_wd,
    output logic [31:0] mcause_wd,
    output logic [31:0] mtval_wd,
    output logic        mie_clr,
    output logic        mie_restore,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RET    = 2'd3
    } state_t;

    localparam logic [31:0] IRQ_CAUSE_W = 32'(IRQ_CAUSE);

    // Trap target: direct base, or base + 4*code for interrupts in vectored mode.
    function automatic logic [31:0] vector_target(input logic [31:0] tvec,
                                                  input logic [31:0] cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if ((tvec[1:0] == 2'b01) && cause[31]) begin
            // 4*cause[30:0] keeps only the low 30 bits of the code after the shift.
            vector_target = base + {cause[29:0], 2'b00};
        end else begin
            vector_target = base;
        end
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] val_q, val_d;
    logic [31:0] addr_q, addr_d;
    logic        ret_first_q, ret_first_d;

    // Next-state and latch logic; events are only looked at while idle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        val_d       = val_q;
        addr_d      = addr_q;
        ret_first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    pc_d    = trap_pc;
                    cause_d = {1'b0, 26'd0, trap_cause};
                    val_d   = trap_val;
                    state_d = ST_SAVE;
                end else if (irq_ext && mie) begin
                    pc_d    = next_pc;
                    cause_d = {1'b1, IRQ_CAUSE_W[30:0]};
                    val_d   = 32'd0;
                    state_d = ST_SAVE;
                end else if (mret) begin
                    addr_d      = mepc_q;
                    ret_first_d = 1'b1;
                    state_d     = ST_RET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                // mtvec is sampled here so the target is frozen for the whole redirect.
                addr_d  = vector_target(mtvec, cause_q);
                state_d = ST_VECTOR;
            end
            ST_VECTOR, ST_RET: begin
                if (redir_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= 32'd0;
            cause_q     <= 32'd0;
            val_q       <= 32'd0;
            addr_q      <= 32'd0;
            ret_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cause_q     <= cause_d;
            val_q       <= val_d;
            addr_q      <= addr_d;
            ret_first_q <= ret_first_d;
        end
    end

    // Output decode from the registered state and latched data.
    always_comb begin
        flush       = 1'b0;
        redir_valid = 1'b0;
        csr_we      = 1'b0;
        mepc_wd     = 32'd0;
        mcause_wd   = 32'd0;
        mtval_wd    = 32'd0;
        mie_clr     = 1'b0;
        mie_restore = 1'b0;
        case (state_q)
            ST_IDLE: begin
                flush = 1'b0;
            end
            ST_SAVE: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                mie_clr   = 1'b1;
                mepc_wd   = pc_q;
                mcause_wd = cause_q;
                mtval_wd  = val_q;
            end
            ST_VECTOR: begin
                redir_valid = 1'b1;
            end
            ST_RET: begin
                redir_valid = 1'b1;
                flush       = ret_first_q;
                // MIE comes back exactly when fetch takes the return target.
                mie_restore = redir_ready;
            end
            default: begin
                flush = 1'b0;
            end
        endcase
    end

    assign redir_addr = addr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
